// File: rtl/clock_pkg.sv
// Shared definitions for the clock/alarm datapath: alarm state encoding,
// time limits and the hour/minute normalisers reused by the time-set path.
package clock_pkg;

   typedef enum logic [1:0] {
      DISARMED = 2'd0,
      ARMED    = 2'd1,
      RINGING  = 2'd2,
      SNOOZING = 2'd3
   } alarm_state_e;

   localparam logic [3:0] HOUR_MAX = 4'd12;
   localparam logic [5:0] MIN_MAX  = 6'd59;

   // 0 reads as 12 o'clock; 13..15 fold back onto the 12-hour dial.
   function automatic logic [3:0] norm_hour(input logic [3:0] h);
      if (h == 4'd0)
         return HOUR_MAX;
      else if (h > HOUR_MAX)
         return h - HOUR_MAX;
      else
         return h;
   endfunction

   function automatic logic [5:0] norm_min(input logic [5:0] m);
      if (m > MIN_MAX)
         return 6'd0;
      else
         return m;
   endfunction

endpackage

// File: rtl/alarm_controller_btn_edge.sv
// Registered rising-edge detector; the history register resets high so a
// button already held when reset releases never fires.
module btn_edge (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic btn_i,
   output logic rise_o
);

   logic prev_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni)
         prev_q <= 1'b1;
      else
         prev_q <= btn_i;
   end

   assign rise_o = btn_i & ~prev_q;

endmodule

// File: rtl/alarm_controller.sv
// Alarm stage behind the 12-hour clock core: stores the alarm time and runs
// the arm/ring/snooze/dismiss machine on the one-second tick.
module alarm_controller
   import clock_pkg::*;
#(
   parameter int unsigned RING_SECS   = 60,
   parameter int unsigned SNOOZE_SECS = 300,
   parameter int unsigned MAX_SNOOZES = 3
) (
   input  logic                                 oneSecClk,
   input  logic                                 reset,
   input  logic [3:0]                           cur_hour,
   input  logic [5:0]                           cur_min,
   input  logic [5:0]                           cur_sec,
   input  logic                                 clk_running,
   input  logic [3:0]                           set_hour,
   input  logic [5:0]                           set_min,
   input  logic                                 load_alarm,
   input  logic                                 arm_sw,
   input  logic                                 snooze_btn,
   input  logic                                 dismiss_btn,
   output logic                                 buzzer,
   output logic                                 alarm_led,
   output logic [1:0]                           state,
   output logic [$clog2(MAX_SNOOZES+1)-1:0]     snooze_cnt,
   output logic [3:0]                           alarm_hour,
   output logic [5:0]                           alarm_min
);

   localparam int unsigned SC_W   = $clog2(MAX_SNOOZES + 1);
   localparam int unsigned RING_W = (RING_SECS > 1) ? $clog2(RING_SECS) : 1;
   localparam int unsigned SNZ_W  = (SNOOZE_SECS > 1) ? $clog2(SNOOZE_SECS) : 1;

   alarm_state_e      state_q;
   logic              phase_q;
   logic [RING_W-1:0] ring_q;
   logic [SNZ_W-1:0]  snz_q;
   logic [SC_W-1:0]   snooze_q;
   logic [3:0]        ahour_q;
   logic [5:0]        amin_q;

   logic snooze_rise;
   logic dismiss_rise;
   logic match;

   btn_edge u_snooze_edge (
      .clk_i  (oneSecClk),
      .rst_ni (reset),
      .btn_i  (snooze_btn),
      .rise_o (snooze_rise)
   );

   btn_edge u_dismiss_edge (
      .clk_i  (oneSecClk),
      .rst_ni (reset),
      .btn_i  (dismiss_btn),
      .rise_o (dismiss_rise)
   );

   assign match = (cur_hour == ahour_q) && (cur_min == amin_q) &&
                  (cur_sec == 6'd0) && clk_running;

   always_ff @(posedge oneSecClk) begin
      if (!reset) begin
         state_q  <= DISARMED;
         phase_q  <= 1'b0;
         ring_q   <= '0;
         snz_q    <= '0;
         snooze_q <= '0;
         ahour_q  <= HOUR_MAX;
         amin_q   <= '0;
      end else begin
         if (load_alarm) begin
            ahour_q <= norm_hour(set_hour);
            amin_q  <= norm_min(set_min);
         end
         unique case (state_q)
            DISARMED: begin
               if (arm_sw)
                  state_q <= ARMED;
            end
            ARMED: begin
               if (!arm_sw) begin
                  state_q <= DISARMED;
               end else if (match) begin
                  state_q  <= RINGING;
                  ring_q   <= RING_W'(RING_SECS - 1);
                  snooze_q <= '0;
                  phase_q  <= 1'b1;
               end
            end
            // A snooze press with no snoozes left falls through to the ring timer.
            RINGING: begin
               if (!arm_sw) begin
                  state_q <= DISARMED;
               end else if (dismiss_rise) begin
                  state_q <= ARMED;
               end else if (snooze_rise && (snooze_q < SC_W'(MAX_SNOOZES))) begin
                  state_q  <= SNOOZING;
                  snz_q    <= SNZ_W'(SNOOZE_SECS - 1);
                  snooze_q <= snooze_q + SC_W'(1);
               end else if (ring_q == '0) begin
                  state_q <= ARMED;
               end else begin
                  ring_q  <= ring_q - RING_W'(1);
                  phase_q <= ~phase_q;
               end
            end
            SNOOZING: begin
               if (!arm_sw) begin
                  state_q <= DISARMED;
               end else if (dismiss_rise) begin
                  state_q <= ARMED;
               end else if (snz_q == '0) begin
                  state_q <= RINGING;
                  ring_q  <= RING_W'(RING_SECS - 1);
                  phase_q <= 1'b1;
               end else begin
                  snz_q <= snz_q - SNZ_W'(1);
               end
            end
            default: state_q <= DISARMED;
         endcase
      end
   end

   assign state      = state_q;
   assign buzzer     = (state_q == RINGING) && phase_q;
   assign alarm_led  = (state_q == RINGING) || (state_q == SNOOZING);
   assign snooze_cnt = snooze_q;
   assign alarm_hour = ahour_q;
   assign alarm_min  = amin_q;

endmodule

// File: tb/tb_alarm_controller.sv
// Directed bench for alarm_controller: stimulus queues the expected post-edge
// outputs, a negedge monitor pops and compares them.
module tb_alarm_controller;

   logic       oneSecClk = 1'b0;
   logic       reset;
   logic [3:0] cur_hour;
   logic [5:0] cur_min;
   logic [5:0] cur_sec;
   logic       clk_running;
   logic [3:0] set_hour;
   logic [5:0] set_min;
   logic       load_alarm;
   logic       arm_sw;
   logic       snooze_btn;
   logic       dismiss_btn;
   logic       buzzer;
   logic       alarm_led;
   logic [1:0] state;
   logic [1:0] snooze_cnt;
   logic [3:0] alarm_hour;
   logic [5:0] alarm_min;

   alarm_controller #(
      .RING_SECS   (60),
      .SNOOZE_SECS (300),
      .MAX_SNOOZES (3)
   ) dut (
      .oneSecClk   (oneSecClk),
      .reset       (reset),
      .cur_hour    (cur_hour),
      .cur_min     (cur_min),
      .cur_sec     (cur_sec),
      .clk_running (clk_running),
      .set_hour    (set_hour),
      .set_min     (set_min),
      .load_alarm  (load_alarm),
      .arm_sw      (arm_sw),
      .snooze_btn  (snooze_btn),
      .dismiss_btn (dismiss_btn),
      .buzzer      (buzzer),
      .alarm_led   (alarm_led),
      .state       (state),
      .snooze_cnt  (snooze_cnt),
      .alarm_hour  (alarm_hour),
      .alarm_min   (alarm_min)
   );

   always #5 oneSecClk = ~oneSecClk;

   // mask bits: 0 state, 1 buzzer, 2 led, 3 snooze_cnt, 4 alarm_hour, 5 alarm_min
   typedef struct {
      string      name;
      logic [5:0] mask;
      logic [1:0] st;
      logic       bz;
      logic       led;
      logic [1:0] sc;
      logic [3:0] ah;
      logic [5:0] am;
   } exp_t;

   exp_t q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic chk(input string nm, input string fld, input int act, input int req);
      n_tests++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s.%s: got %0d, expected %0d", nm, fld, act, req);
      end
   endtask

   always @(negedge oneSecClk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         if (e.mask[0]) chk(e.name, "state",      int'(state),      int'(e.st));
         if (e.mask[1]) chk(e.name, "buzzer",     int'(buzzer),     int'(e.bz));
         if (e.mask[2]) chk(e.name, "alarm_led",  int'(alarm_led),  int'(e.led));
         if (e.mask[3]) chk(e.name, "snooze_cnt", int'(snooze_cnt), int'(e.sc));
         if (e.mask[4]) chk(e.name, "alarm_hour", int'(alarm_hour), int'(e.ah));
         if (e.mask[5]) chk(e.name, "alarm_min",  int'(alarm_min),  int'(e.am));
      end
   end

   // Queue one expectation for the next edge, then advance past that edge.
   task automatic tick(input string nm, input logic [5:0] m, input logic [1:0] st,
                       input logic bz, input logic led, input logic [1:0] sc,
                       input logic [3:0] ah, input logic [5:0] am);
      exp_t e;
      e.name = nm; e.mask = m; e.st = st; e.bz = bz; e.led = led;
      e.sc = sc; e.ah = ah; e.am = am;
      q.push_back(e);
      @(posedge oneSecClk);
      #1;
   endtask

   task automatic tick_st(input string nm, input logic [1:0] st);
      tick(nm, 6'b000001, st, 1'b0, 1'b0, 2'd0, 4'd0, 6'd0);
   endtask

   task automatic tick_ring(input string nm, input logic [1:0] st, input logic bz,
                            input logic led, input logic [1:0] sc);
      tick(nm, 6'b001111, st, bz, led, sc, 4'd0, 6'd0);
   endtask

   // Snooze from RINGING, sit out the full snooze, then confirm the re-ring.
   task automatic do_snooze(input logic [1:0] n);
      snooze_btn = 1'b1;
      tick_ring("snooze_enter", 2'd3, 1'b0, 1'b1, n);
      snooze_btn = 1'b0;
      for (int i = 0; i < 299; i++)
         tick_st("snoozing", 2'd3);
      tick_ring("snooze_reRing", 2'd2, 1'b1, 1'b1, n);
   endtask

   initial begin
      reset = 1'b0; arm_sw = 1'b1; clk_running = 1'b1;
      cur_hour = 4'd1; cur_min = 6'd0; cur_sec = 6'd1;
      set_hour = 4'd0; set_min = 6'd0; load_alarm = 1'b0;
      snooze_btn = 1'b0; dismiss_btn = 1'b0;

      tick("reset", 6'b111111, 2'd0, 1'b0, 1'b0, 2'd0, 4'd12, 6'd0);
      reset = 1'b1;
      tick_st("armAfterReset", 2'd1);

      set_hour = 4'd7; set_min = 6'd30; load_alarm = 1'b1;
      tick("load730", 6'b110001, 2'd1, 1'b0, 1'b0, 2'd0, 4'd7, 6'd30);
      load_alarm = 1'b0;

      cur_hour = 4'd7; cur_min = 6'd30; cur_sec = 6'd0; clk_running = 1'b0;
      tick_st("pausedNoMatch", 2'd1);
      clk_running = 1'b1;
      tick_ring("ringStart", 2'd2, 1'b1, 1'b1, 2'd0);
      cur_sec = 6'd1;
      tick_ring("beepOff", 2'd2, 1'b0, 1'b1, 2'd0);
      tick_ring("beepOn", 2'd2, 1'b1, 1'b1, 2'd0);
      for (int i = 3; i < 60; i++)
         tick("ringing", 6'b000011, 2'd2, (i % 2 == 0), 1'b0, 2'd0, 4'd0, 6'd0);
      tick_ring("timeout", 2'd1, 1'b0, 1'b0, 2'd0);

      cur_sec = 6'd0;
      tick_ring("ring2Start", 2'd2, 1'b1, 1'b1, 2'd0);
      cur_sec = 6'd1;
      do_snooze(2'd1);
      do_snooze(2'd2);
      do_snooze(2'd3);
      snooze_btn = 1'b1;
      tick_ring("snooze4Ignored", 2'd2, 1'b0, 1'b1, 2'd3);
      snooze_btn = 1'b0;
      dismiss_btn = 1'b1;
      tick_ring("dismissRing", 2'd1, 1'b0, 1'b0, 2'd3);
      dismiss_btn = 1'b0;

      cur_sec = 6'd0;
      tick_ring("ring3Start", 2'd2, 1'b1, 1'b1, 2'd0);
      cur_sec = 6'd1; snooze_btn = 1'b1;
      tick_ring("snzEnter", 2'd3, 1'b0, 1'b1, 2'd1);
      snooze_btn = 1'b0; dismiss_btn = 1'b1;
      tick_ring("dismissSnz", 2'd1, 1'b0, 1'b0, 2'd1);
      dismiss_btn = 1'b0;
      tick_st("armedIdle", 2'd1);

      dismiss_btn = 1'b1;
      tick_st("dismissHeldArmed", 2'd1);
      cur_sec = 6'd0;
      tick_ring("ring4Start", 2'd2, 1'b1, 1'b1, 2'd0);
      cur_sec = 6'd1; arm_sw = 1'b0;
      tick_ring("disarmRing", 2'd0, 1'b0, 1'b0, 2'd0);
      dismiss_btn = 1'b0;

      set_hour = 4'd0; set_min = 6'd63; load_alarm = 1'b1;
      tick("load0_63", 6'b110001, 2'd0, 1'b0, 1'b0, 2'd0, 4'd12, 6'd0);
      set_hour = 4'd14; set_min = 6'd5;
      tick("load14", 6'b110000, 2'd0, 1'b0, 1'b0, 2'd0, 4'd2, 6'd5);
      set_hour = 4'd15; set_min = 6'd59;
      tick("load15", 6'b110000, 2'd0, 1'b0, 1'b0, 2'd0, 4'd3, 6'd59);
      set_hour = 4'd7; set_min = 6'd30;
      arm_sw = 1'b1;
      tick("load730Arm", 6'b110001, 2'd1, 1'b0, 1'b0, 2'd0, 4'd7, 6'd30);
      load_alarm = 1'b0;

      cur_sec = 6'd0;
      tick_ring("ring5Start", 2'd2, 1'b1, 1'b1, 2'd0);
      cur_sec = 6'd1; reset = 1'b0; snooze_btn = 1'b1;
      tick("resetMidRing", 6'b111111, 2'd0, 1'b0, 1'b0, 2'd0, 4'd12, 6'd0);
      reset = 1'b1;
      tick_st("rearm", 2'd1);
      cur_hour = 4'd12; cur_min = 6'd0; cur_sec = 6'd0;
      tick_ring("ring12", 2'd2, 1'b1, 1'b1, 2'd0);
      cur_sec = 6'd1;
      tick_ring("heldSnoozeNoFire", 2'd2, 1'b0, 1'b1, 2'd0);
      snooze_btn = 1'b0;

      for (int i = 0; i < 5 && q.size() > 0; i++)
         @(negedge oneSecClk);
      #1;
      if (q.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain: got %0d pending, expected 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
